cursor_input_ctrl: RTL and testbench
====================================

# cursor_input_ctrl

Front-end controller that turns raw board buttons into the coordinate and strobe signals consumed by the GoBang datapath. It debounces five keys, moves a cursor across the 16x16 board with wrap-around, and on a put request issues the ordered strobe sequence the datapath expects: `change_able_read`, then `put`, then `turn_control`. It sits between the board pins and the datapath and is the initiator for that datapath's put/turn interface.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a key level change. At 50 MHz this is 10 ms. Minimum value is 2.
- `RESET_COORD`, default 8'h77: cursor position after reset. Bits 7:4 are the row, bits 3:0 the column.

Ports:
- `clock`, in, 1: the single clock; all logic is rising-edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_put`, in, 1 each: raw, asynchronous, active-high (pressed = 1).
- `game_over`, in, 1: high when the datapath's win check is nonzero.
- `coordi`, out, 8: cursor position. Bits 7:4 are the row, bits 3:0 the column.
- `change_able_read`, out, 1: one-cycle strobe that records the validity of the target cell.
- `put`, out, 1: two-cycle high pulse; the datapath writes on its rising edge.
- `turn_control`, out, 1: one-cycle strobe that requests a player change.
- `busy`, out, 1: high while a put sequence is in progress.

## Operation
- **Input conditioning.** Each key passes through a 2-flop synchronizer, then an independent debouncer.
  - The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any sample that agrees with the current level clears the counter.
- **Events.** A press event is a single-cycle pulse on the debounced 0->1 transition. Releases generate no event.
- **Movement**, applied in state IDLE only:
  - up: row-1. down: row+1. left: col-1. right: col+1.
  - Arithmetic is 4-bit modulo 16: row 0 on up goes to 15; col 15 on right goes to 0.
  - up and down events in the same cycle leave the row unchanged. left and right in the same cycle leave the column unchanged.
  - Row and column moves in the same cycle both apply.
- **FSM states:** IDLE, CHOICE, PUT1, PUT2, TURN, WAIT_REL.
  - IDLE -> CHOICE: on a put event with `game_over`=0. Movement events in that same cycle are discarded.
  - A put event with `game_over`=1 is ignored; movement still works.
  - CHOICE -> PUT1 -> PUT2 -> TURN: unconditional, one cycle each.
  - TURN -> WAIT_REL: unconditional.
  - WAIT_REL -> IDLE: when debounced `key_put` = 0. If it is already 0 on entry, the transition happens on the next cycle.
- **Outputs per state:**
  - `change_able_read`=1 in CHOICE only.
  - `put`=1 in PUT1 and PUT2.
  - `turn_control`=1 in TURN only.
  - `busy`=1 in every state except IDLE.
  - All strobes are registered outputs, glitch-free.
- **Coordinate freeze.** `coordi` is frozen from CHOICE through WAIT_REL. Movement events in those states are dropped, not queued.
- **Game over mid-sequence.** A `game_over` rise during a sequence does not abort it.

## Timing
- **Reset values:** `coordi`=`RESET_COORD`; `put`, `turn_control`, `change_able_read` and `busy` all 0; FSM in IDLE.
- **Reset state of conditioning logic:** debounced levels 0, counters 0, synchronizers 0.
- **Reset mid-sequence:** on the first clock edge with `resetn`=0, all outputs take their reset values, including `put` dropping to 0.
  - A key still held when reset is released is seen as a new press after debounce.
- **Key latency:** a clean raw edge at cycle 0 produces the press event at cycle 2 + `DEBOUNCE_CYCLES`, ±1 for synchronizer phase.
  - For movement, `coordi` updates on the following edge.
- **Put sequence:** with the put event registered in IDLE at cycle T:
  - `change_able_read` is high in cycle T+1.
  - `put` is high in cycles T+2 and T+3.
  - `turn_control` is high in cycle T+4.
  - `busy` is high from T+1 onward until the return to IDLE.
- **Ordering guarantee:** `coordi` is stable for at least 1 cycle before `change_able_read` and through the end of TURN.
- **Minimum spacing:** two put sequences are separated by at least one release debounce plus one press debounce.

## Test plan
Use `DEBOUNCE_CYCLES`=4 for all scenarios.
- **Reset:** assert `resetn`=0 for 2 cycles with random keys toggling -> `coordi`=8'h77 and all strobes/`busy` 0; no strobe fires.
- **Bounce:** `key_right` toggles every 2 cycles for 20 cycles, then holds high -> exactly one column increment (8'h77 -> 8'h78), timed per the key latency rule.
- **Wrap:** from reset, 8 `key_up` presses -> `coordi`=8'hF7. Then `key_up` and `key_down` pressed in the same cycle -> `coordi` stays 8'hF7.
- **Put sequence:** press `key_put` at 8'h35 and hold -> `change_able_read`, `put`, `put`, `turn_control` in 4 consecutive cycles. `busy` stays 1 while the key is held, and `key_left` presses in that window leave `coordi`=8'h35. After release and debounce, `busy`=0.
- **Game over:** with `game_over`=1, press `key_put` -> no strobes and `busy`=0. Press `key_down` -> row increments.
- **Reset mid-put:** pull `resetn` low in the PUT1 cycle -> `put`=0 and `coordi`=8'h77 on the next edge; no `turn_control` pulse occurs.

Source files
------------

// File: rtl/cursor_input_ctrl_if.sv
// cursor_input_ctrl_if: datapath-side bus (coordi/strobes/busy from the controller, game_over back to it)
interface cursor_input_ctrl_if;
    logic [7:0] coordi;
    logic       change_able_read;
    logic       put;
    logic       turn_control;
    logic       busy;
    logic       game_over;
    modport master (output coordi, change_able_read, put, turn_control, busy, input game_over);
    modport slave (input coordi, change_able_read, put, turn_control, busy, output game_over);
endinterface

// File: rtl/cursor_input_ctrl.sv
// cursor_input_ctrl: debounces 5 keys (clock/resetn/key_* in, bus master out) and drives cursor + put/turn strobes
module cursor_input_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] RESET_COORD     = 8'h77
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       key_up,
    input  logic                       key_down,
    input  logic                       key_left,
    input  logic                       key_right,
    input  logic                       key_put,
    cursor_input_ctrl_if.master        bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [2:0] {IDLE, CHOICE, PUT1, PUT2, TURN, WAIT_REL} state_t;
    state_t        state, state_n;
    logic [4:0]    raw, s1, s2, lvl, lvl_q, ev;
    logic [CW-1:0] cnt [5];
    logic [3:0]    row_n, col_n;
    logic          move;
    assign raw = {key_put, key_right, key_left, key_down, key_up};
    assign ev  = lvl & ~lvl_q;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = (ev[4] && !bus.game_over) ? CHOICE : IDLE;
            CHOICE:   state_n = PUT1;
            PUT1:     state_n = PUT2;
            PUT2:     state_n = TURN;
            TURN:     state_n = WAIT_REL;
            WAIT_REL: state_n = lvl[4] ? WAIT_REL : IDLE;
            default:  state_n = IDLE;
        endcase
        // moves only while staying in IDLE; a starting put swallows same-cycle moves
        move  = (state == IDLE) && (state_n == IDLE);
        row_n = bus.coordi[7:4] + ((ev[0] && !ev[1]) ? 4'hF : (ev[1] && !ev[0]) ? 4'h1 : 4'h0);
        col_n = bus.coordi[3:0] + ((ev[2] && !ev[3]) ? 4'hF : (ev[3] && !ev[2]) ? 4'h1 : 4'h0);
    end
    // strobes are decoded from the next state and registered, so they come straight off flops
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state                <= IDLE;
            bus.coordi           <= RESET_COORD;
            bus.change_able_read <= 1'b0;
            bus.put              <= 1'b0;
            bus.turn_control     <= 1'b0;
            bus.busy             <= 1'b0;
        end else begin
            state                <= state_n;
            bus.coordi           <= move ? {row_n, col_n} : bus.coordi;
            bus.change_able_read <= state_n == CHOICE;
            bus.put              <= (state_n == PUT1) || (state_n == PUT2);
            bus.turn_control     <= state_n == TURN;
            bus.busy             <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_cursor_input_ctrl.sv
// tb_cursor_input_ctrl: directed self-checking bench for cursor_input_ctrl with DEBOUNCE_CYCLES=4
module tb_cursor_input_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] keys = '0;
    int         n_cmp = 0, n_err = 0;
    int         n_cr = 0, n_put = 0, n_turn = 0;
    cursor_input_ctrl_if bus ();
    cursor_input_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_COORD(8'h77)) dut (
        .clock(clock), .resetn(resetn),
        .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]), .key_right(keys[3]), .key_put(keys[4]),
        .bus(bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (bus.change_able_read === 1'b1) n_cr++;
        if (bus.put === 1'b1) n_put++;
        if (bus.turn_control === 1'b1) n_turn++;
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic tap(input logic [4:0] m);
        keys = keys | m;
        cyc(10);
        keys = keys & ~m;
        cyc(10);
    endtask
    task automatic apply_reset();
        resetn = 1'b0;
        keys = '0;
        cyc(3);
        resetn = 1'b1;
        cyc(1);
    endtask
    task automatic test_reset();
        bus.game_over = 1'b0;
        resetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            keys = 5'($urandom);
            cyc(1);
        end
        keys = '0;
        cyc(3);
        n_cmp++; if (bus.coordi !== 8'h77) begin n_err++; $display("FAIL reset_coordi: got %h want 77", bus.coordi); end
        n_cmp++; if ({bus.change_able_read, bus.put, bus.turn_control, bus.busy} !== 4'b0) begin n_err++; $display("FAIL reset_outputs: got %b want 0000", {bus.change_able_read, bus.put, bus.turn_control, bus.busy}); end
        resetn = 1'b1;
        cyc(10);
        n_cmp++; if (n_cr + n_put + n_turn !== 0) begin n_err++; $display("FAIL reset_no_strobe: got %0d strobe cycles want 0", n_cr + n_put + n_turn); end
        n_cmp++; if (bus.coordi !== 8'h77) begin n_err++; $display("FAIL reset_idle_coordi: got %h want 77", bus.coordi); end
    endtask
    task automatic test_bounce();
        logic [7:0] prev;
        int changes = 0, at = -1;
        apply_reset();
        prev = bus.coordi;
        for (int c = 0; c < 40; c++) begin
            keys[3] = (c >= 20) || ((c / 2) % 2 == 0);
            cyc(1);
            if (bus.coordi !== prev) begin
                changes++;
                at = c;
                prev = bus.coordi;
            end
        end
        n_cmp++; if (changes !== 1) begin n_err++; $display("FAIL bounce_changes: got %0d want 1", changes); end
        n_cmp++; if (bus.coordi !== 8'h78) begin n_err++; $display("FAIL bounce_coordi: got %h want 78", bus.coordi); end
        n_cmp++; if (at < 25 || at > 27) begin n_err++; $display("FAIL bounce_latency: got cycle %0d want 25..27", at); end
        keys = '0;
        cyc(10);
    endtask
    task automatic test_wrap();
        apply_reset();
        tap(5'b00001);
        n_cmp++; if (bus.coordi !== 8'h67) begin n_err++; $display("FAIL wrap_first_up: got %h want 67", bus.coordi); end
        for (int i = 0; i < 7; i++) tap(5'b00001);
        n_cmp++; if (bus.coordi !== 8'hF7) begin n_err++; $display("FAIL wrap_row: got %h want F7", bus.coordi); end
        tap(5'b00011);
        n_cmp++; if (bus.coordi !== 8'hF7) begin n_err++; $display("FAIL wrap_up_down: got %h want F7", bus.coordi); end
        tap(5'b01000);
        n_cmp++; if (bus.coordi !== 8'hF8) begin n_err++; $display("FAIL wrap_right: got %h want F8", bus.coordi); end
    endtask
    task automatic test_put_seq();
        bit seen = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) tap(5'b00001);
        tap(5'b00100);
        tap(5'b00100);
        n_cmp++; if (bus.coordi !== 8'h35) begin n_err++; $display("FAIL put_setup: got %h want 35", bus.coordi); end
        keys[4] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            cyc(1);
            seen = bus.change_able_read === 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL put_choice_timeout: got no change_able_read want one within 20 cycles"); end
        n_cmp++; if ({bus.put, bus.turn_control, bus.busy} !== 3'b001) begin n_err++; $display("FAIL put_choice: got put/turn/busy %b want 001", {bus.put, bus.turn_control, bus.busy}); end
        cyc(1);
        n_cmp++; if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b010) begin n_err++; $display("FAIL put_put1: got cr/put/turn %b want 010", {bus.change_able_read, bus.put, bus.turn_control}); end
        cyc(1);
        n_cmp++; if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b010) begin n_err++; $display("FAIL put_put2: got cr/put/turn %b want 010", {bus.change_able_read, bus.put, bus.turn_control}); end
        cyc(1);
        n_cmp++; if ({bus.change_able_read, bus.put, bus.turn_control} !== 3'b001) begin n_err++; $display("FAIL put_turn: got cr/put/turn %b want 001", {bus.change_able_read, bus.put, bus.turn_control}); end
        cyc(1);
        n_cmp++; if ({bus.turn_control, bus.busy} !== 2'b01) begin n_err++; $display("FAIL put_wait: got turn/busy %b want 01", {bus.turn_control, bus.busy}); end
        tap(5'b00100);
        n_cmp++; if (bus.coordi !== 8'h35) begin n_err++; $display("FAIL put_freeze: got %h want 35", bus.coordi); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL put_busy_held: got %b want 1", bus.busy); end
        keys[4] = 1'b0;
        cyc(12);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL put_busy_release: got %b want 0", bus.busy); end
    endtask
    task automatic test_game_over();
        int s0 = n_cr + n_put + n_turn;
        bit busy_seen = 0;
        bus.game_over = 1'b1;
        keys[4] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) keys[4] = 1'b0;
            cyc(1);
            busy_seen = busy_seen | (bus.busy !== 1'b0);
        end
        n_cmp++; if (n_cr + n_put + n_turn !== s0) begin n_err++; $display("FAIL go_no_strobe: got %0d strobe cycles want 0", n_cr + n_put + n_turn - s0); end
        n_cmp++; if (busy_seen) begin n_err++; $display("FAIL go_busy: got busy seen want never"); end
        tap(5'b00010);
        n_cmp++; if (bus.coordi !== 8'h45) begin n_err++; $display("FAIL go_down: got %h want 45", bus.coordi); end
        bus.game_over = 1'b0;
    endtask
    task automatic test_reset_mid_put();
        bit seen = 0;
        int t0;
        keys[4] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            cyc(1);
            seen = bus.change_able_read === 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rmp_choice_timeout: got no change_able_read want one within 20 cycles"); end
        cyc(1);
        n_cmp++; if (bus.put !== 1'b1) begin n_err++; $display("FAIL rmp_put1: got %b want 1", bus.put); end
        t0 = n_turn;
        resetn = 1'b0;
        keys = '0;
        cyc(1);
        n_cmp++; if (bus.put !== 1'b0) begin n_err++; $display("FAIL rmp_put_drop: got %b want 0", bus.put); end
        n_cmp++; if (bus.coordi !== 8'h77) begin n_err++; $display("FAIL rmp_coordi: got %h want 77", bus.coordi); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmp_busy: got %b want 0", bus.busy); end
        cyc(2);
        resetn = 1'b1;
        cyc(12);
        n_cmp++; if (n_turn !== t0) begin n_err++; $display("FAIL rmp_no_turn: got %0d turn cycles want 0", n_turn - t0); end
    endtask
    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_put_seq();
        test_game_over();
        test_reset_mid_put();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
